csr_row_mac_stream: RTL and testbench

Streaming, pipelined CSR row dot-product engine: consumes a row's nonzeros as (value, gathered vector element) pairs, LANES per beat, accumulates signed products and emits one row result per row with a valid/ready handshake. Sits between the CSR fetch/gather unit (val/col/rowPtr walkers, vector lookup) and the SpMV result writer. It replaces the purely combinational per-row evaluator with a clocked, back-pressurable datapath whose width, lane count and per-row nonzero cap are parameters.

---
 rtl/csr_row_mac_stream.sv | 102 ++++++++++
 tb/tb_csr_row_mac_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/csr_row_mac_stream.sv
// csr_row_mac_stream: pipelined CSR row dot-product engine with valid/ready on both sides.
// Define CSR_ROW_MAC_SAT_EN for a saturating accumulator with sticky out_ovf; otherwise the accumulator wraps.
module csr_row_mac_stream #(
   parameter int DATA_W  = 32,
   parameter int ACC_W   = 64,
   parameter int LANES   = 2,
   parameter int MAX_NNZ = 16,
   parameter int ROW_W   = 16,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_val,
   input  logic [LANES*DATA_W-1:0]   in_vec,
   input  logic [LANES-1:0]          in_mask,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_data,
   output logic [ROW_W-1:0]          out_row,
   output logic [CNT_W-1:0]          out_count,
   output logic                      out_trunc,
   output logic                      out_ovf
);
   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
   localparam int PW = 2 * DATA_W;
`ifdef CSR_ROW_MAC_SAT_EN
   localparam int SW = ACC_W + 5;
`else
   localparam int SW = ACC_W;
`endif
   state_t state, state_n;
   logic accept, hs, trunc, trunc_n;
   logic [LANES-1:0] admit;
   logic [CNT_W+3:0] seen;
   logic [CNT_W-1:0] count, count_n;
   logic [ROW_W-1:0] row;
   logic signed [PW-1:0] prod [LANES];
   logic signed [ACC_W-1:0] acc, acc_n;
   logic signed [SW-1:0] sum_w, acc_w;
   assign in_ready  = rst && state == ACCUM;
   assign out_valid = state == HOLD;
   assign accept    = in_valid && in_ready;
   assign hs        = out_valid && out_ready;
   assign out_data  = acc;
   assign out_row   = row;
   assign out_count = count;
   assign out_trunc = trunc;
   always_comb begin
      state_n = state == ACCUM ? (accept && in_last ? DRAIN : ACCUM) :
                state == DRAIN ? HOLD : (hs ? ACCUM : HOLD);
   end
   // Lane k is admitted while its rank among this row's real nonzeros is below MAX_NNZ.
   always_comb begin
      seen = (CNT_W+4)'(count);
      trunc_n = trunc;
      admit = '0;
      for (int k = 0; k < LANES; k++) begin
         admit[k] = in_mask[k] && seen < (CNT_W+4)'(MAX_NNZ);
         trunc_n = trunc_n | (in_mask[k] && !admit[k]);
         seen = seen + (CNT_W+4)'(in_mask[k]);
      end
      count_n = |seen[CNT_W+3:CNT_W] ? '1 : seen[CNT_W-1:0];
   end
   always_comb begin
      sum_w = '0;
      for (int k = 0; k < LANES; k++) sum_w = sum_w + SW'(prod[k]);
      acc_w = SW'(acc) + sum_w;
   end
`ifdef CSR_ROW_MAC_SAT_EN
   logic ovf, ovf_now;
   assign ovf_now = acc_w[SW-1:ACC_W-1] != {(SW-ACC_W+1){acc_w[SW-1]}};
   assign acc_n   = ovf_now ? (acc_w[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                            : acc_w[ACC_W-1:0];
   assign out_ovf = ovf;
   always_ff @(posedge clk) ovf <= !rst || hs ? 1'b0 : ovf | ovf_now;
`else
   assign acc_n   = acc_w;
   assign out_ovf = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
         trunc <= 1'b0;
         row   <= '0;
         for (int k = 0; k < LANES; k++) prod[k] <= '0;
      end else begin
         state <= state_n;
         for (int k = 0; k < LANES; k++)
            prod[k] <= accept && admit[k] ? PW'($signed(in_val[k*DATA_W +: DATA_W])) *
                                            PW'($signed(in_vec[k*DATA_W +: DATA_W])) : '0;
         acc   <= hs ? '0 : acc_n;
         count <= hs ? '0 : accept ? count_n : count;
         trunc <= hs ? 1'b0 : accept ? trunc_n : trunc;
         row   <= row + ROW_W'(hs);
      end
   end
endmodule

// File: tb/tb_csr_row_mac_stream.sv
// tb_csr_row_mac_stream: directed rows checked against a beat-level arithmetic model of row results.
module tb_csr_row_mac_stream;
   localparam int DATA_W = 32, ACC_W = 64, LANES = 2, MAX_NNZ = 16, ROW_W = 16, CNT_W = 16;
   localparam logic signed [127:0] MAXV = (128'sd1 <<< 63) - 128'sd1;
   localparam logic signed [127:0] MINV = -(128'sd1 <<< 63);
   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [LANES*DATA_W-1:0] in_val = '0, in_vec = '0;
   logic [LANES-1:0] in_mask = '0;
   logic in_ready, out_valid, out_trunc, out_ovf;
   logic [ACC_W-1:0] out_data;
   logic [ROW_W-1:0] out_row;
   logic [CNT_W-1:0] out_count;
   csr_row_mac_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES), .MAX_NNZ(MAX_NNZ),
                        .ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
      .in_vec(in_vec), .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_count(out_count),
      .out_trunc(out_trunc), .out_ovf(out_ovf));
   always #5 clk = ~clk;
   typedef struct {logic [63:0] data; logic [15:0] count; logic trunc; logic ovf; logic [15:0] row;} res_t;
   res_t exp_q[$];
   res_t last_push;
   int hs_cyc[$];
   int n_checks = 0, n_pass = 0, cyc = 0;
   longint m_cnt = 0;
   logic signed [127:0] m_acc = 0;
   bit m_trunc = 0, m_ovf = 0;
   int m_row = 0;
   always @(posedge clk) cyc++;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
   endtask
   function automatic logic [63:0] pk(input int a0, input int a1);
      return {a1, a0};
   endfunction
   function automatic void model_clear();
      m_cnt = 0; m_acc = 0; m_trunc = 0; m_ovf = 0;
   endfunction
   // Row result from the rules: first MAX_NNZ real nonzeros contribute, all are counted.
   function automatic void model_beat(input logic [63:0] v, input logic [63:0] w, input logic [1:0] m, input bit last);
      logic signed [127:0] add = 0;
      for (int k = 0; k < LANES; k++) begin
         longint a = longint'($signed(v[k*32 +: 32]));
         longint b = longint'($signed(w[k*32 +: 32]));
         if (m[k]) begin
            if (m_cnt < MAX_NNZ) add += a * b;
            else m_trunc = 1;
            m_cnt++;
         end
      end
      m_acc += add;
`ifdef CSR_ROW_MAC_SAT_EN
      if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1; end
      if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1; end
`else
      m_acc = {{64{m_acc[63]}}, m_acc[63:0]};
`endif
      if (last) begin
         last_push = '{m_acc[63:0], m_cnt > 65535 ? 16'hFFFF : 16'(m_cnt), m_trunc, m_ovf, 16'(m_row)};
         exp_q.push_back(last_push);
         m_row++;
         model_clear();
      end
   endfunction
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out_valid: got row %0d data %0h want no result", out_row, out_data);
         end else begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_count", out_count, exp_q[0].count);
            chk("out_trunc", out_trunc, exp_q[0].trunc);
            chk("out_ovf", out_ovf, exp_q[0].ovf);
            chk("out_row", out_row, exp_q[0].row);
            if (out_ready) begin
               hs_cyc.push_back(cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end
   task automatic send_beat(input logic [63:0] v, input logic [63:0] w, input logic [1:0] m, input bit last, output int iters);
      bit ok = 0;
      in_valid = 1; in_val = v; in_vec = w; in_mask = m; in_last = last;
      iters = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
         iters++;
      end
      if (ok) model_beat(v, w, m, last);
      else begin n_checks++; $display("FAIL beat_accept: got no in_ready want accept within 50 cycles"); end
      in_valid = 0; in_last = 0;
   endtask
   task automatic do_reset(input int n);
      rst = 0; #1;
      chk("in_ready_in_reset", in_ready, 0);
      exp_q.delete(); model_clear(); m_row = 0;
      repeat (n) begin @(posedge clk); #1; end
      in_valid = 0; in_last = 0;
      rst = 1; #1;
      chk("in_ready_after_reset", in_ready, 1);
      chk("out_valid_after_reset", out_valid, 0);
      chk("out_row_after_reset", out_row, 0);
   endtask
   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending results want 0", exp_q.size());
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      int it;
      @(posedge clk); #1;
      do_reset(2);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_count", out_count, 0);
      chk("reset_out_trunc", out_trunc, 0);
      chk("reset_out_ovf", out_ovf, 0);
      out_ready = 1;
      send_beat(pk(3, 4), pk(5, 6), 2'b11, 1, it);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("t2_out_valid", out_valid, 1);
      chk("t2_out_data", out_data, 39);
      chk("t2_out_count", out_count, 2);
      chk("t2_out_row", out_row, 0);
      @(posedge clk); #1;
      chk("post_hs_in_ready", in_ready, 1);
      hs_cyc.delete();
      send_beat(pk(3, 4), pk(5, 6), 2'b11, 1, it);
      chk("model_row_a", last_push.data, 39);
      send_beat(pk(2, -3), pk(3, 6), 2'b11, 1, it);
      chk("model_row_b", last_push.data, -12);
      send_beat(pk(9, 9), pk(9, 9), 2'b00, 1, it);
      chk("model_row_empty", last_push.data, 0);
      drain();
      if (hs_cyc.size() == 3) begin
         chk("row_period_1", hs_cyc[1] - hs_cyc[0], 3);
         chk("row_period_2", hs_cyc[2] - hs_cyc[1], 3);
      end else begin
         n_checks++;
         $display("FAIL row_period: got %0d handshakes want 3", hs_cyc.size());
      end
      for (int b = 0; b < 10; b++) send_beat(pk(1, 1), pk(1, 1), 2'b11, b == 9, it);
      chk("model_trunc_data", last_push.data, 16);
      chk("model_trunc_count", last_push.count, 20);
      chk("model_trunc_flag", last_push.trunc, 1);
      drain();
      out_ready = 0;
      send_beat(pk(2, -1), pk(5, 5), 2'b11, 1, it);
      for (int i = 0; i < 5 && !out_valid; i++) begin @(posedge clk); #1; end
      in_valid = 1; in_val = pk(2, 0); in_vec = pk(7, 0); in_mask = 2'b01; in_last = 1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_out_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1;
      @(posedge clk); #1;
      chk("release_in_ready", in_ready, 1);
      send_beat(pk(2, 0), pk(7, 0), 2'b01, 1, it);
      chk("release_accept_cycles", it, 1);
      drain();
      send_beat(pk(32'h7FFFFFFF, 32'h7FFFFFFF), pk(32'h7FFFFFFF, 32'h7FFFFFFF), 2'b11, 0, it);
      send_beat(pk(32'h7FFFFFFF, 32'h7FFFFFFF), pk(32'h7FFFFFFF, 32'h7FFFFFFF), 2'b11, 1, it);
`ifdef CSR_ROW_MAC_SAT_EN
      chk("model_sat_data", last_push.data, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("model_sat_ovf", last_push.ovf, 1);
`else
      chk("model_wrap_data", last_push.data, 64'hFFFF_FFFC_0000_0004);
      chk("model_wrap_ovf", last_push.ovf, 0);
`endif
      drain();
      send_beat(pk(1, 1), pk(1, 1), 2'b11, 0, it);
      in_valid = 1; in_val = pk(5, 5); in_vec = pk(5, 5); in_mask = 2'b11; in_last = 1;
      do_reset(1);
      send_beat(pk(2, 0), pk(7, 0), 2'b01, 1, it);
      chk("model_after_reset_data", last_push.data, 14);
      chk("model_after_reset_row", last_push.row, 0);
      drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
